// File: rtl/midi_msg_assembler.sv
`default_nettype none
// ============================================================================
// Module   : midi_msg_assembler
// Purpose  : Frames raw MIDI bytes into complete messages. Handles running
//            status, SysEx skipping and real-time bypass, and queues messages
//            in a small valid/ready FIFO.
// Options  : MIDI_CH_FILTER_EN - drop channel messages not addressed to midi_ch
// Revision : 1.0 - initial release
// ============================================================================
module midi_msg_assembler #(
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          sysclk,
    input  logic          reset1,
    input  logic          byte_valid,
    input  logic [7:0]    byte_in,
    input  logic [3:0]    midi_ch,
    output logic          msg_valid,
    input  logic          msg_ready,
    output logic [7:0]    msg_status,
    output logic [6:0]    msg_data1,
    output logic [6:0]    msg_data2,
    output logic [1:0]    msg_len,
    output logic          rt_valid,
    output logic [7:0]    rt_byte,
    output logic          overflow,
    output logic [CW-1:0] fifo_count
);

    localparam int            ADDR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2,
        ST_SYSEX   = 2'd3
    } state_t;

    // Reset asserts immediately and releases two clocks later, in sync with sysclk.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge sysclk or negedge reset1) begin
        if (!reset1) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_t      state_q, state_d;
    logic [7:0]  status_q, status_d;
    logic [6:0]  data1_q, data1_d;
    logic        rt_valid_q, rt_valid_d;
    logic [7:0]  rt_byte_q, rt_byte_d;
    logic        emit_valid_q, emit_valid_d;
    logic [23:0] emit_msg_q, emit_msg_d;

    logic is_channel;
    logic one_data;
    logic pass_ch;

    assign is_channel = status_q[7] && (status_q[7:4] != 4'hF);
    assign one_data   = (status_q[7:5] == 3'b110) || (status_q == 8'hF1) || (status_q == 8'hF3);

`ifdef MIDI_CH_FILTER_EN
    assign pass_ch = !is_channel || (status_q[3:0] == midi_ch);
`else
    logic midi_ch_unused;
    assign midi_ch_unused = ^midi_ch;
    assign pass_ch        = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        data1_d      = data1_q;
        rt_valid_d   = 1'b0;
        rt_byte_d    = rt_byte_q;
        emit_valid_d = 1'b0;
        emit_msg_d   = emit_msg_q;
        if (byte_valid) begin
            if (byte_in >= 8'hF8) begin
                rt_valid_d = 1'b1;
                rt_byte_d  = byte_in;
            end else if (byte_in[7]) begin
                // Any non-real-time status aborts the partial message, SysEx included.
                data1_d = 7'd0;
                if (byte_in < 8'hF0) begin
                    status_d = byte_in;
                    state_d  = ST_WAIT_D1;
                end else begin
                    case (byte_in)
                        8'hF0: begin
                            status_d = 8'h00;
                            state_d  = ST_SYSEX;
                        end
                        8'hF1, 8'hF2, 8'hF3: begin
                            status_d = byte_in;
                            state_d  = ST_WAIT_D1;
                        end
                        8'hF6: begin
                            status_d     = 8'h00;
                            state_d      = ST_IDLE;
                            emit_valid_d = 1'b1;
                            emit_msg_d   = {8'hF6, 7'd0, 7'd0, 2'd0};
                        end
                        default: begin
                            status_d = 8'h00;
                            state_d  = ST_IDLE;
                        end
                    endcase
                end
            end else begin
                case (state_q)
                    ST_WAIT_D1: begin
                        if (one_data) begin
                            emit_valid_d = pass_ch;
                            emit_msg_d   = {status_q, byte_in[6:0], 7'd0, 2'd1};
                            if (!is_channel) begin
                                status_d = 8'h00;
                                state_d  = ST_IDLE;
                            end
                        end else begin
                            data1_d = byte_in[6:0];
                            state_d = ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: begin
                        emit_valid_d = pass_ch;
                        emit_msg_d   = {status_q, data1_q, byte_in[6:0], 2'd2};
                        if (is_channel) begin
                            state_d = ST_WAIT_D1;
                        end else begin
                            status_d = 8'h00;
                            state_d  = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [23:0]       mem_q [FIFO_DEPTH];
    logic [23:0]       mem_d [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              pop;
    logic              push_ok;

    assign pop     = (count_q != '0) && msg_ready;
    assign push_ok = emit_valid_q && ((count_q != FULL_COUNT) || pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (emit_valid_q && !push_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = emit_msg_q;
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            status_q     <= 8'h00;
            data1_q      <= 7'd0;
            rt_valid_q   <= 1'b0;
            rt_byte_q    <= 8'h00;
            emit_valid_q <= 1'b0;
            emit_msg_q   <= 24'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 24'd0;
            end
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            data1_q      <= data1_d;
            rt_valid_q   <= rt_valid_d;
            rt_byte_q    <= rt_byte_d;
            emit_valid_q <= emit_valid_d;
            emit_msg_q   <= emit_msg_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            mem_q        <= mem_d;
        end
    end

    assign msg_valid  = (count_q != '0);
    assign {msg_status, msg_data1, msg_data2, msg_len} = mem_q[rd_ptr_q];
    assign rt_valid   = rt_valid_q;
    assign rt_byte    = rt_byte_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_msg_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_midi_msg_assembler
// Purpose  : Directed and randomized checking of midi_msg_assembler against a
//            byte-stream reference model (honours MIDI_CH_FILTER_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_midi_msg_assembler;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          sysclk = 1'b0;
    logic          reset1 = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic [3:0]    midi_ch = 4'd2;
    logic          msg_valid;
    logic          msg_ready = 1'b0;
    logic [7:0]    msg_status;
    logic [6:0]    msg_data1;
    logic [6:0]    msg_data2;
    logic [1:0]    msg_len;
    logic          rt_valid;
    logic [7:0]    rt_byte;
    logic          overflow;
    logic [CW-1:0] fifo_count;

    midi_msg_assembler #(.FIFO_DEPTH(DEPTH), .CW(CW)) dut (
        .sysclk     (sysclk),
        .reset1     (reset1),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .midi_ch    (midi_ch),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_status (msg_status),
        .msg_data1  (msg_data1),
        .msg_data2  (msg_data2),
        .msg_len    (msg_len),
        .rt_valid   (rt_valid),
        .rt_byte    (rt_byte),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [7:0] st;
        logic [6:0] d1;
        logic [6:0] d2;
        logic [1:0] len;
    } msg_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: message queue, one-cycle emit pipeline, stream parser.
    msg_t       exp_q[$];
    msg_t       pend;
    bit         pend_v;
    bit         exp_ovf;
    bit         exp_rt_v;
    logic [7:0] exp_rt_b;
    logic [7:0] cur;
    bit         in_sysex;
    logic [6:0] partial[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int needed(input logic [7:0] s);
        if (s == 8'hF2)                                return 2;
        if (s == 8'hF1 || s == 8'hF3)                  return 1;
        if (s[7:4] == 4'hC || s[7:4] == 4'hD)          return 1;
        return 2;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        partial.delete();
        pend_v   = 0;
        exp_ovf  = 0;
        exp_rt_v = 0;
        exp_rt_b = 8'h00;
        cur      = 8'h00;
        in_sysex = 0;
    endtask

    task automatic model_emit(input logic [7:0] s);
        msg_t m;
        bit   keep;
        m.st  = s;
        m.len = 2'(partial.size());
        m.d1  = (partial.size() > 0) ? partial[0] : 7'd0;
        m.d2  = (partial.size() > 1) ? partial[1] : 7'd0;
        keep  = 1;
`ifdef MIDI_CH_FILTER_EN
        if (s < 8'hF0 && s[3:0] != midi_ch) keep = 0;
`endif
        if (keep) begin
            pend   = m;
            pend_v = 1;
        end
    endtask

    task automatic model_parse(input logic [7:0] b);
        if (b >= 8'hF8) begin
            exp_rt_v = 1;
            exp_rt_b = b;
        end else if (b[7]) begin
            partial.delete();
            in_sysex = 0;
            cur      = 8'h00;
            if (b < 8'hF0)                               cur = b;
            else if (b == 8'hF0)                         in_sysex = 1;
            else if (b == 8'hF1 || b == 8'hF2 || b == 8'hF3) cur = b;
            else if (b == 8'hF6)                         model_emit(8'hF6);
        end else if (!in_sysex && cur != 8'h00) begin
            partial.push_back(b[6:0]);
            if (partial.size() == needed(cur)) begin
                model_emit(cur);
                partial.delete();
                if (cur >= 8'hF0) cur = 8'h00;
            end
        end
    endtask

    task automatic model_step(input bit bv, input logic [7:0] b, input bit rdy);
        if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        if (pend_v) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(pend);
            else                      exp_ovf = 1;
        end
        pend_v   = 0;
        exp_rt_v = 0;
        if (bv) model_parse(b);
    endtask

    task automatic check_outputs();
        check("msg_valid", 32'(msg_valid), 32'(exp_q.size() > 0));
        check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("rt_valid", 32'(rt_valid), 32'(exp_rt_v));
        check("rt_byte", 32'(rt_byte), 32'(exp_rt_b));
        if (exp_q.size() > 0) begin
            check("msg_status", 32'(msg_status), 32'(exp_q[0].st));
            check("msg_data1", 32'(msg_data1), 32'(exp_q[0].d1));
            check("msg_data2", 32'(msg_data2), 32'(exp_q[0].d2));
            check("msg_len", 32'(msg_len), 32'(exp_q[0].len));
        end
    endtask

    task automatic cycle(input bit bv, input logic [7:0] b, input bit rdy);
        @(negedge sysclk);
        byte_valid = bv;
        byte_in    = b;
        msg_ready  = rdy;
        @(posedge sysclk);
        model_step(bv, b, rdy);
        #1;
        check_outputs();
    endtask

    task automatic put(input logic [7:0] b, input bit rdy);
        cycle(1'b1, b, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy);
    endtask

    task automatic apply_reset();
        @(negedge sysclk);
        reset1     = 1'b0;
        byte_valid = 1'b0;
        msg_ready  = 1'b0;
        #1;
        model_reset();
        check("rst_msg_valid", 32'(msg_valid), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_rt_valid", 32'(rt_valid), 32'd0);
        check("rst_rt_byte", 32'(rt_byte), 32'd0);
        check("rst_head", {msg_status, msg_data1, msg_data2, msg_len}, 32'd0);
        @(posedge sysclk);
        @(negedge sysclk);
        reset1 = 1'b1;
        idle(3, 1'b0);
    endtask

    int         thresh;
    int         r;
    logic [7:0] b;
    bit         bv;

    initial begin
        model_reset();
        repeat (3) @(posedge sysclk);
        apply_reset();

        // Basic note-on, then latency is covered by the per-cycle model.
        put(8'h90, 1'b0); put(8'h3C, 1'b0); put(8'h64, 1'b0);
        idle(2, 1'b0); idle(2, 1'b1);

        // Running status.
        put(8'h90, 1'b1); put(8'h3C, 1'b1); put(8'h64, 1'b1);
        put(8'h40, 1'b1); put(8'h00, 1'b1);
        idle(3, 1'b1);

        // One-byte channel messages, then SysEx with embedded real-time.
        put(8'hC5, 1'b0); put(8'h07, 1'b0); put(8'h08, 1'b0);
        put(8'hF0, 1'b0); put(8'h01, 1'b0); put(8'h02, 1'b0);
        put(8'hF8, 1'b0); put(8'hF7, 1'b0);
        idle(4, 1'b1);

        // Interleaved real-time inside a note message.
        put(8'h90, 1'b1); put(8'h3C, 1'b1); put(8'hF8, 1'b1); put(8'h64, 1'b1);
        put(8'h40, 1'b1); put(8'h7F, 1'b1);
        idle(3, 1'b1);

        // System common: F2 two bytes, F3 one byte, F6 none.
        put(8'hF2, 1'b1); put(8'h11, 1'b1); put(8'h22, 1'b1);
        put(8'hF3, 1'b1); put(8'h05, 1'b1); put(8'h06, 1'b1);
        put(8'hF6, 1'b1);
        idle(3, 1'b1);

        // Overflow: FIFO_DEPTH+1 note-ons with the consumer stalled.
        for (int i = 0; i < DEPTH + 1; i++) begin
            put(8'h90, 1'b0); put(8'(8'h30 + i), 1'b0); put(8'h50, 1'b0);
        end
        idle(2, 1'b0);
        check("ovf_count_full", 32'(fifo_count), 32'(DEPTH));
        check("ovf_sticky", 32'(overflow), 32'd1);
        idle(DEPTH + 2, 1'b1);

        // Reset mid-message clears FIFO, overflow and the partial message.
        put(8'h90, 1'b0); put(8'h3C, 1'b0); put(8'h64, 1'b0); put(8'h3D, 1'b0);
        apply_reset();
        put(8'h64, 1'b1);
        idle(2, 1'b1);

        // Channel filter scenario.
        midi_ch = 4'd2;
        put(8'h92, 1'b0); put(8'h3C, 1'b0); put(8'h64, 1'b0);
        put(8'h91, 1'b0); put(8'h3C, 1'b0); put(8'h64, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Randomized stream with shifting consumer pressure.
        thresh = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                r = int'($urandom_range(0, 2));
                thresh = (r == 0) ? 10 : ((r == 1) ? 50 : 90);
            end
            if (i % 500 == 250) midi_ch = 4'($urandom_range(0, 3));
            r = int'($urandom_range(0, 99));
            if (r < 55)      b = 8'($urandom_range(0, 127));
            else if (r < 80) b = 8'($urandom_range(8'h80, 8'hEF));
            else if (r < 90) b = 8'($urandom_range(8'hF0, 8'hF7));
            else             b = 8'($urandom_range(8'hF8, 8'hFF));
            bv = ($urandom_range(0, 99) < 75);
            cycle(bv, b, ($urandom_range(0, 99) < thresh));
            if (i == 2000) apply_reset();
        end
        idle(DEPTH + 3, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
